// File: rtl/rect_draw_engine_pkg.sv
// Shared definitions for the rectangle fill engine and the game-logic FSM:
// screen geometry, field widths, palette, engine state encoding and the
// request record.
package rect_draw_engine_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COORD_W  = 8;
  localparam int COLOUR_W = 3;

  // One bit per channel: {R, G, B}
  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
  localparam logic [COLOUR_W-1:0] RED   = 3'b100;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  // Engine state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Captured rectangle request
  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COORD_W-1:0]  w;
    logic [COORD_W-1:0]  h;
    logic [COLOUR_W-1:0] colour;
  } rect_req_t;

  // Absolute coordinates carry one extra bit so x+col never wraps back
  // onto the visible area.
  function automatic logic on_screen(input logic [COORD_W:0] ax,
                                     input logic [COORD_W:0] ay);
    return (ax < (COORD_W+1)'(SCREEN_W)) && (ay < (COORD_W+1)'(SCREEN_H));
  endfunction

endpackage

// File: rtl/rect_draw_engine_scan_counter.sv
// Column/row raster counter for the fill engine. Column is the inner loop
// and wraps at w-1. nxt_col/nxt_row expose the position being loaded this
// cycle so the top can register the matching pixel on the same edge.
import rect_draw_engine_pkg::*;

module rect_scan_counter #(
  parameter int W = COORD_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         advance,
  input  logic [W-1:0] w,
  input  logic [W-1:0] h,
  output logic [W-1:0] nxt_col,
  output logic [W-1:0] nxt_row,
  output logic         last
);

  logic [W-1:0] col;
  logic [W-1:0] row;
  logic         col_end;

  assign col_end = (col == w - W'(1));
  assign last    = col_end && (row == h - W'(1));

  // Next position: load restarts at the origin, advance steps in raster order
  always_comb begin
    nxt_col = col;
    nxt_row = row;
    if (load) begin
      nxt_col = '0;
      nxt_row = '0;
    end else if (advance) begin
      if (col_end) begin
        nxt_col = '0;
        nxt_row = row + W'(1);
      end else begin
        nxt_col = col + W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle fill engine. Accepts one rectangle request at a time and
// streams one pixel per clock onto the vga_adapter write port, clipping
// anything beyond the visible screen while still spending its cycle.
import rect_draw_engine_pkg::*;

module rect_draw_engine (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COORD_W-1:0]  req_x,
  input  logic [COORD_W-1:0]  req_y,
  input  logic [COORD_W-1:0]  req_w,
  input  logic [COORD_W-1:0]  req_h,
  input  logic [COLOUR_W-1:0] req_colour,
  output logic                busy,
  output logic                done,
  output logic [COORD_W-1:0]  pix_x,
  output logic [COORD_W-1:0]  pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                pix_plot
);

  logic [1:0]         state, state_nxt;
  rect_req_t          req_in, lat, base;
  logic               accept, empty, load, advance, last;
  logic [COORD_W-1:0] nxt_col, nxt_row;
  logic [COORD_W:0]   abs_x, abs_y;
  logic               plot_nxt, done_nxt;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign req_in  = {req_x, req_y, req_w, req_h, req_colour};
  assign accept  = req_valid && req_ready;
  assign empty   = (req_w == '0) || (req_h == '0);
  assign load    = accept && !empty;
  assign advance = (state == DRAW) && !last;

  rect_scan_counter #(.W(COORD_W)) u_scan (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .w       (lat.w),
    .h       (lat.h),
    .nxt_col (nxt_col),
    .nxt_row (nxt_row),
    .last    (last)
  );

  // Pixel 0 is produced on the accepting edge, before the request is captured
  assign base     = load ? req_in : lat;
  assign abs_x    = {1'b0, base.x} + {1'b0, nxt_col};
  assign abs_y    = {1'b0, base.y} + {1'b0, nxt_row};
  assign plot_nxt = (load || advance) && on_screen(abs_x, abs_y);
  assign done_nxt = (accept && empty) || ((state == DRAW) && last);

  // Engine sequencing: IDLE -> DRAW -> DONE -> IDLE, empty requests skip DRAW
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = empty ? DONE : DRAW;
      DRAW:    if (last)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and captured request
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) lat <= req_in;
    end
  end

  // Registered adapter outputs; address and colour are zero whenever not plotting
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_plot   <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_colour <= '0;
      done       <= 1'b0;
    end else begin
      pix_plot   <= plot_nxt;
      pix_x      <= plot_nxt ? abs_x[COORD_W-1:0] : '0;
      pix_y      <= plot_nxt ? abs_y[COORD_W-1:0] : '0;
      pix_colour <= plot_nxt ? base.colour : '0;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Bench for rect_draw_engine: a table of rectangles plus hand-written
// sequences for back-to-back acceptance and reset mid-draw. Expected
// per-cycle outputs come from a simple raster/clip model and are queued
// when each request is driven, then popped and compared every cycle.
module tb_rect_draw_engine;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x, req_y, req_w, req_h;
  logic [2:0] req_colour;
  logic       busy, done;
  logic [7:0] pix_x, pix_y;
  logic [2:0] pix_colour;
  logic       pix_plot;

  rect_draw_engine dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .busy       (busy),
    .done       (done),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .pix_plot   (pix_plot)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       done;
    logic       busy;
    logic       ready;
  } exp_t;

  typedef struct {
    string name;
    int    x, y, w, h, c;
    int    exp_plots;
  } vec_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    plot_cnt;
  string cur_name;

  // Expected outputs for the first 'count' pixels of a rectangle
  function automatic void push_pixels(int x, int y, int w, int h, int c, int count);
    int n = 0;
    for (int r = 0; r < h; r++) begin
      for (int cc = 0; cc < w; cc++) begin
        exp_t e;
        int ax, ay;
        if (n < count) begin
          ax = x + cc;
          ay = y + r;
          e.plot  = (ax < 160) && (ay < 120);
          e.x     = e.plot ? ax[7:0] : 8'd0;
          e.y     = e.plot ? ay[7:0] : 8'd0;
          e.c     = e.plot ? c[2:0] : 3'd0;
          e.done  = 1'b0;
          e.busy  = 1'b1;
          e.ready = 1'b0;
          q.push_back(e);
        end
        n++;
      end
    end
  endfunction

  function automatic void push_idle();
    exp_t e;
    e.plot = 1'b0; e.x = 8'd0; e.y = 8'd0; e.c = 3'd0;
    e.done = 1'b0; e.busy = 1'b0; e.ready = 1'b1;
    q.push_back(e);
  endfunction

  // Full request: every pixel, one done cycle, then back to idle
  function automatic void push_req(int x, int y, int w, int h, int c);
    exp_t e;
    push_pixels(x, y, w, h, c, w * h);
    e.plot = 1'b0; e.x = 8'd0; e.y = 8'd0; e.c = 3'd0;
    e.done = 1'b1; e.busy = 1'b1; e.ready = 1'b0;
    q.push_back(e);
    push_idle();
  endfunction

  // Drive a request just after a negedge; it is accepted on the next posedge
  task automatic issue(input int x, input int y, input int w, input int h,
                       input int c, input bit hold);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_issue: got req_ready=%b want 1", cur_name, req_ready);
    end
    req_x = x[7:0]; req_y = y[7:0]; req_w = w[7:0]; req_h = h[7:0]; req_colour = c[2:0];
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      // Junk on the request bus must not disturb the captured rectangle
      req_x = 8'($urandom); req_y = 8'($urandom);
      req_w = 8'($urandom); req_h = 8'($urandom);
      req_colour = 3'($urandom);
    end
  endtask

  // Pop and compare one record per cycle until the queue is empty
  task automatic drain(input int release_at);
    int i = 0;
    while (q.size() > 0) begin
      exp_t e;
      @(negedge clock);
      e = q.pop_front();
      if (pix_plot === 1'b1) plot_cnt++;
      checks++;
      if ({pix_plot, pix_x, pix_y, pix_colour, done, busy, req_ready} !==
          {e.plot, e.x, e.y, e.c, e.done, e.busy, e.ready}) begin
        errors++;
        $display("FAIL %s cycle %0d: got plot=%b x=%0d y=%0d c=%0d done=%b busy=%b ready=%b, want plot=%b x=%0d y=%0d c=%0d done=%b busy=%b ready=%b",
                 cur_name, i, pix_plot, pix_x, pix_y, pix_colour, done, busy, req_ready,
                 e.plot, e.x, e.y, e.c, e.done, e.busy, e.ready);
      end
      if (i == release_at) req_valid = 1'b0;
      i++;
    end
  endtask

  task automatic check_plots(input int want);
    checks++;
    if (plot_cnt != want) begin
      errors++;
      $display("FAIL %s plot_count: got %0d want %0d", cur_name, plot_cnt, want);
    end
  endtask

  // Watchdog: the whole run is about 20k cycles
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{"paddle",    76, 110, 16, 2, 7, 32};
    vecs[1] = '{"clip",     155, 118,  8, 4, 2, 10};
    vecs[2] = '{"zero_w",    10,  10,  0, 5, 3,  0};
    vecs[3] = '{"zero_h",    10,  10,  4, 0, 3,  0};
    vecs[4] = '{"overflow", 250,   5, 10, 1, 1,  0};
    vecs[5] = '{"corner",   159, 119,  1, 1, 5,  1};
    vecs[6] = '{"bottom",    40, 117,  3, 5, 4,  9};

    reset = 1'b1; req_valid = 1'b0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    cur_name = "reset_idle";
    plot_cnt = 0;
    push_idle(); push_idle();
    drain(-1);

    // Table-driven rectangles
    for (int v = 0; v < 7; v++) begin
      cur_name = vecs[v].name;
      plot_cnt = 0;
      issue(vecs[v].x, vecs[v].y, vecs[v].w, vecs[v].h, vecs[v].c, 1'b0);
      push_req(vecs[v].x, vecs[v].y, vecs[v].w, vecs[v].h, vecs[v].c);
      drain(-1);
      check_plots(vecs[v].exp_plots);
    end

    // Full-screen clear with a second request held valid on the bus throughout
    cur_name = "clear_b2b";
    plot_cnt = 0;
    issue(0, 0, 160, 120, 0, 1'b1);
    req_x = 8'd3; req_y = 8'd4; req_w = 8'd2; req_h = 8'd1; req_colour = 3'd4;
    push_req(0, 0, 160, 120, 0);
    push_req(3, 4, 2, 1, 4);
    drain(160 * 120 + 2);
    check_plots(160 * 120 + 2);

    // Reset asserted while pixel 5 of an 8x2 block is on the outputs
    cur_name = "reset_mid";
    plot_cnt = 0;
    issue(20, 30, 8, 2, 6, 1'b0);
    push_pixels(20, 30, 8, 2, 6, 6);
    drain(-1);
    reset = 1'b1;
    push_idle();
    drain(-1);
    reset = 1'b0;
    push_idle(); push_idle();
    drain(-1);
    check_plots(6);

    cur_name = "after_reset_1x1";
    plot_cnt = 0;
    issue(80, 108, 1, 1, 7, 1'b0);
    push_req(80, 108, 1, 1, 7);
    drain(-1);
    check_plots(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
Rectangle fill engine between the game-logic FSM and vga_adapter. Game logic issues one request per rectangle (paddle, ball, block, erase, full-screen clear). The engine streams one pixel per clock as x/y/colour/plot, which feed the adapter's write port directly. Game logic no longer keeps per-object draw counters.

Parameters:
SCREEN_W, 160, visible width in pixels; pixels with absolute x >= SCREEN_W are clipped
SCREEN_H, 120, visible height in pixels; pixels with absolute y >= SCREEN_H are clipped
COORD_W, 8, width of coordinate and size fields
COLOUR_W, 3, colour width (1 bit per channel)

Ports:
clock  in  1  system clock (CLOCK_50 at top level)
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  engine can accept a request
req_x  in  COORD_W  top-left x
req_y  in  COORD_W  top-left y
req_w  in  COORD_W  width in pixels (0 = empty)
req_h  in  COORD_W  height in pixels (0 = empty)
req_colour  in  COLOUR_W  fill colour
busy  out  1  high in DRAW and DONE
done  out  1  one-cycle pulse when a request completes
pix_x  out  COORD_W  pixel x to adapter
pix_y  out  COORD_W  pixel y to adapter
pix_colour  out  COLOUR_W  pixel colour to adapter
pix_plot  out  1  write enable to adapter

Behaviour:
- Reset:
  - state=IDLE; pix_x, pix_y, pix_colour, pix_plot, done and busy all 0.
  - Column and row counters cleared.
  - req_ready=1 in the first cycle after reset deasserts.
- req_ready is combinational: (state==IDLE).
- Acceptance happens at an edge where req_valid && req_ready.
  - x, y, w, h and colour are latched at that edge; later changes to req_* are ignored until the next acceptance.
- States:
  - IDLE: if accepted and (w==0 or h==0), go to DONE; if accepted otherwise, go to DRAW; else stay.
  - DRAW: emit one pixel per cycle in raster order, column inner loop.
    - col runs 0..w-1; on col==w-1, col wraps to 0 and row increments.
    - After the pixel at (w-1, h-1) is emitted, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Pixel outputs are registered. For an acceptance at edge k:
  - pixel n (n = 0..w*h-1) is on pix_* during cycle k+1+n;
  - done is high in cycle k+1+w*h;
  - req_ready returns in cycle k+2+w*h.
  - An empty request gives done in cycle k+1 and no plots.
- Pixel address arithmetic:
  - Absolute x = x+col and y+row, computed COORD_W+1 bits wide so no wrap-around occurs.
  - If abs_x >= SCREEN_W or abs_y >= SCREEN_H, the pixel is clipped: pix_plot=0 and pix_x/pix_y/pix_colour=0. The cycle is still consumed, so latency is independent of clipping.
  - Otherwise pix_plot=1 and pix_x/pix_y are the low COORD_W bits of the absolute coordinates.
- Whenever pix_plot=0 (IDLE, DONE, clipped pixel), pix_x, pix_y and pix_colour are all 0.
- Colour 0 (black) is a normal fill, used for erase and clear.
- busy = (state!=IDLE).
- done never coincides with pix_plot=1.
- Reset during DRAW or DONE:
  - the request is aborted with no done pulse;
  - all outputs are 0 at the next edge;
  - req_ready=1 the following cycle.
- req_valid held high through completion does not re-accept until IDLE; the back-to-back request rate is one per w*h+2 cycles.

Decomposition:
- Shared package (used by the game-logic FSM too):
  - SCREEN_W, SCREEN_H, COORD_W, COLOUR_W
  - colour constants BLACK=3'b000, GREEN=3'b010, RED=3'b100, WHITE=3'b111
  - engine state encoding IDLE/DRAW/DONE
- One sub-module, rect_scan_counter: col/row counters with load, advance, wrap at w-1, and a last-pixel flag.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then 0 → req_ready=1, pix_plot=0, done=0, all pix_* 0.
- Paddle draw: x=76, y=110, w=16, h=2, colour=7 → 32 consecutive plots.
  - Order: (76..91,110), then (76..91,111).
  - done exactly 33 cycles after acceptance; req_ready low throughout.
- Right/bottom clip: x=155, y=118, w=8, h=4, colour=2 → 32 pixel cycles, only 10 plotted.
  - Plotted pixels: x=155..159 at y=118,119.
  - All other cycles have pix_plot=0 and pix_x/pix_y=0; done at cycle 33.
- Zero-size and overflow: w=0, h=5 → done in the cycle after acceptance, no plots.
  - x=250, w=10, h=1 → 10 cycles, zero plots (no 8-bit wrap to x=0..3).
- Full clear then back-to-back: x=0, y=0, w=160, h=120, colour=0 → 19200 plots, last at (159,119).
  - A second request held valid is accepted in the cycle req_ready reasserts.
  - The bench checks the captured fields ignore req_* changes made mid-draw.
- Reset mid-draw: assert reset on pixel 5 of an 8x2 block → no done pulse, all outputs 0 next cycle.
  - req_ready=1 after that.
  - A new 1x1 request at (80,108) plots exactly one pixel.
